// File: rtl/sdc_wb_script_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdc_wb_script_master                                                     |
// | Step-table driven Wishbone master: WRITE / READ / POLL / END steps with  |
// | per-cycle ack timeout and bounded polling.                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sdc_wb_script_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 5,
    parameter int ACK_TIMEOUT = 255,
    parameter int POLL_LIMIT  = 1023,
    parameter int POLL_GAP    = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic [IDX_W-1:0]    step_idx,
    input  logic [1:0]          step_op,
    input  logic [ADDR_W-1:0]   step_adr,
    input  logic [DATA_W-1:0]   step_dat,
    input  logic [DATA_W-1:0]   step_mask,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [IDX_W-1:0]    err_step
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_BUS   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ACK  = 2'b01;
    localparam logic [1:0] ERR_POLL = 2'b10;

    localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int POLL_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  step_idx_q, step_idx_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [IDX_W-1:0]  err_step_q, err_step_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic w_poll_match;
    assign w_poll_match = ((wb_dat_i & mask_q) == (dat_q & mask_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            step_idx_q <= '0;
            op_q       <= OP_END;
            adr_q      <= '0;
            dat_q      <= '0;
            mask_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_code_q <= ERR_NONE;
            err_step_q <= '0;
            ack_cnt_q  <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            op_q       <= op_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            mask_q     <= mask_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_code_q <= err_code_d;
            err_step_q <= err_step_d;
            ack_cnt_q  <= ack_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        op_d       = op_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        mask_d     = mask_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_code_d = err_code_q;
        err_step_d = err_step_q;
        ack_cnt_d  = ack_cnt_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_FETCH;
                    step_idx_d = '0;
                    err_code_d = ERR_NONE;
                    err_step_d = '0;
                    poll_cnt_d = '0;
                end
            end
            S_FETCH: begin
                op_d      = step_op;
                adr_d     = step_adr;
                dat_d     = step_dat;
                mask_d    = step_mask;
                ack_cnt_d = '0;
                state_d   = (step_op == OP_END) ? S_DONE : S_BUS;
            end
            S_BUS: begin
                if (wb_ack_i) begin
                    ack_cnt_d = '0;
                    if (op_q == OP_WRITE) begin
                        step_idx_d = step_idx_q + IDX_W'(1);
                        state_d    = S_FETCH;
                    end else if (op_q == OP_READ) begin
                        rd_data_d  = wb_dat_i;
                        rd_valid_d = 1'b1;
                        step_idx_d = step_idx_q + IDX_W'(1);
                        state_d    = S_FETCH;
                    end else begin
                        rd_data_d = wb_dat_i;
                        if (w_poll_match) begin
                            poll_cnt_d = '0;
                            step_idx_d = step_idx_q + IDX_W'(1);
                            state_d    = S_FETCH;
                        end else if (poll_cnt_q == POLL_LAST) begin
                            err_code_d = ERR_POLL;
                            err_step_d = step_idx_q;
                            state_d    = S_ERROR;
                        end else begin
                            poll_cnt_d = poll_cnt_q + POLL_W'(1);
                            gap_cnt_d  = '0;
                            state_d    = (POLL_GAP == 0) ? S_BUS : S_GAP;
                        end
                    end
                end else if (ack_cnt_q == ACK_LAST) begin
                    // Timeout leaves BUS, so cyc/stb fall on the same edge.
                    err_code_d = ERR_ACK;
                    err_step_d = step_idx_q;
                    state_d    = S_ERROR;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_BUS;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes decode straight from the state flop so reset drops them asynchronously.
    always_comb begin
        wb_cyc_o = (state_q == S_BUS);
        wb_stb_o = (state_q == S_BUS);
        wb_we_o  = (state_q == S_BUS) && (op_q == OP_WRITE);
        wb_sel_o = (state_q == S_BUS) ? '1 : '0;
        wb_adr_o = adr_q;
        wb_dat_o = dat_q;
        step_idx = step_idx_q;
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        busy     = (state_q == S_FETCH) || (state_q == S_BUS) || (state_q == S_GAP);
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERROR);
        err_code = err_code_q;
        err_step = err_step_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdc_wb_script_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdc_wb_script_master                                                  |
// | Step table + Wishbone slave model, scripts checked against a step-level  |
// | reference model. Rev 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_sdc_wb_script_master;

    localparam int ADDR_W = 8, DATA_W = 32, IDX_W = 5;
    localparam int ACK_TIMEOUT = 8, POLL_LIMIT = 4, POLL_GAP = 2;
    localparam int NSTEP = 1 << IDX_W;
    localparam logic [7:0] POLL_ADR = 8'h34, DEAD_ADR = 8'h66;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [IDX_W-1:0] step_idx, err_step;
    logic [1:0] step_op, err_code;
    logic [ADDR_W-1:0] step_adr, wb_adr_o;
    logic [DATA_W-1:0] step_dat, step_mask, wb_dat_o, wb_dat_i, rd_data;
    logic [DATA_W/8-1:0] wb_sel_o;
    logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, rd_valid, busy, done, error;

    always #5 clk = ~clk;

    sdc_wb_script_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W),
        .ACK_TIMEOUT(ACK_TIMEOUT), .POLL_LIMIT(POLL_LIMIT), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .step_idx(step_idx),
        .step_op(step_op), .step_adr(step_adr), .step_dat(step_dat), .step_mask(step_mask),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_step(err_step)
    );

    // Step table
    logic [1:0]  t_op   [NSTEP];
    logic [7:0]  t_adr  [NSTEP];
    logic [31:0] t_dat  [NSTEP];
    logic [31:0] t_mask [NSTEP];
    assign step_op   = t_op[step_idx];
    assign step_adr  = t_adr[step_idx];
    assign step_dat  = t_dat[step_idx];
    assign step_mask = t_mask[step_idx];

    // Slave: register file, one polled status register, never acks DEAD_ADR when dead=1
    logic [31:0] smem [256];
    int unsigned wait_cnt, poll_reads, waits, poll_switch;
    logic [31:0] poll_before, poll_after;
    bit dead, stray;
    int cyc_no;

    always_comb begin
        wb_ack_i = (wb_cyc_o && wb_stb_o && (wait_cnt >= waits) && !(dead && wb_adr_o == DEAD_ADR))
                   || (stray && !wb_cyc_o);
        if (wb_adr_o == POLL_ADR) wb_dat_i = (poll_reads < poll_switch) ? poll_before : poll_after;
        else                      wb_dat_i = smem[wb_adr_o];
    end

    always @(posedge clk) begin
        cyc_no <= cyc_no + 1;
        if (!reset_n) begin
            wait_cnt   <= 0;
            poll_reads <= 0;
            for (int i = 0; i < 256; i++) smem[i] <= 32'h0;
        end else begin
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
            else                                   wait_cnt <= 0;
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_we_o && wb_adr_o == POLL_ADR)
                poll_reads <= poll_reads + 1;
            if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) smem[wb_adr_o] <= wb_dat_o;
        end
    end

    // Monitor
    logic [40:0] obs_q[$], exp_q[$];
    int starts[$];
    int stab_err, sel_err, rdv_cnt, cyc_run, last_run;
    bit in_xfer;
    logic [40:0] cap;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_xfer = 1'b0;
            cyc_run = 0;
        end else begin
            if (wb_cyc_o && wb_stb_o) begin
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    cap = {wb_we_o, wb_adr_o, wb_dat_o};
                    starts.push_back(cyc_no);
                end else if (cap !== {wb_we_o, wb_adr_o, wb_dat_o}) begin
                    stab_err++;
                end
                if (wb_ack_i) begin
                    obs_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0});
                    in_xfer = 1'b0;
                end
            end else begin
                in_xfer = 1'b0;
            end
            if (wb_cyc_o ? (wb_sel_o != 4'hF) : (wb_sel_o != 4'h0 || wb_we_o || wb_stb_o)) sel_err++;
            if (rd_valid) rdv_cnt++;
            if (wb_cyc_o) cyc_run++;
            else begin
                if (cyc_run != 0) last_run = cyc_run;
                cyc_run = 0;
            end
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: walks the script one step at a time
    logic [31:0] mmem [256];
    logic [31:0] m_rd;
    int m_done, m_err_code, m_err_step, m_idx, m_rdv;
    int unsigned m_poll_reads;

    function automatic logic [31:0] m_read(input logic [7:0] adr);
        logic [31:0] v;
        if (adr == POLL_ADR) begin
            v = (m_poll_reads < poll_switch) ? poll_before : poll_after;
            m_poll_reads++;
        end else begin
            v = mmem[adr];
        end
        return v;
    endfunction

    task automatic model_run();
        int idx = 0;
        bit fin = 0;
        bit hit;
        logic [31:0] v;
        m_rdv = 0; m_done = 0; m_err_code = 0; m_err_step = 0;
        exp_q.delete();
        for (int guard = 0; guard < 500 && !fin; guard++) begin
            if (t_op[idx] == 2'b00) begin
                m_done = 1; fin = 1;
            end else if (dead && t_adr[idx] == DEAD_ADR) begin
                m_err_code = 1; m_err_step = idx; fin = 1;
            end else if (t_op[idx] == 2'b01) begin
                exp_q.push_back({1'b1, t_adr[idx], t_dat[idx]});
                mmem[t_adr[idx]] = t_dat[idx];
                idx = (idx + 1) % NSTEP;
            end else if (t_op[idx] == 2'b10) begin
                exp_q.push_back({1'b0, t_adr[idx], 32'h0});
                m_rd = m_read(t_adr[idx]);
                m_rdv++;
                idx = (idx + 1) % NSTEP;
            end else begin
                hit = 0;
                for (int n = 0; n < POLL_LIMIT && !hit; n++) begin
                    exp_q.push_back({1'b0, t_adr[idx], 32'h0});
                    v = m_read(t_adr[idx]);
                    m_rd = v;
                    if (((v ^ t_dat[idx]) & t_mask[idx]) == 0) hit = 1;
                end
                if (hit) idx = (idx + 1) % NSTEP;
                else begin
                    m_err_code = 2; m_err_step = idx; fin = 1;
                end
            end
        end
        m_idx = idx;
    endtask

    task automatic set_step(input int i, input logic [1:0] op, input logic [7:0] adr,
                            input logic [31:0] dat, input logic [31:0] mask);
        t_op[i] = op; t_adr[i] = adr; t_dat[i] = dat; t_mask[i] = mask;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NSTEP; i++) set_step(i, 2'b00, 8'h0, 32'h0, 32'h0);
    endtask

    task automatic run_script(input string name, input int unsigned w, input bit d, input bit s);
        bit finished = 0;
        int n;
        waits = w; dead = d; stray = s;
        m_poll_reads = poll_reads;
        model_run();
        obs_q.delete(); starts.delete();
        stab_err = 0; sel_err = 0; rdv_cnt = 0; last_run = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done || error) finished = 1;
            else if (i == 3 && busy) start = 1'b1;
        end
        start = 1'b0;
        @(negedge clk);
        check_eq({name, "/finished"}, finished, 1);
        check_eq({name, "/done"}, done, m_done);
        check_eq({name, "/error"}, error, m_err_code != 0);
        check_eq({name, "/err_code"}, err_code, m_err_code);
        check_eq({name, "/err_step"}, err_step, m_err_step);
        check_eq({name, "/step_idx"}, step_idx, m_idx);
        check_eq({name, "/rd_data"}, rd_data, m_rd);
        check_eq({name, "/rd_valid_pulses"}, rdv_cnt, m_rdv);
        check_eq({name, "/n_xfers"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq($sformatf("%s/xfer%0d", name, i), obs_q[i], exp_q[i]);
        check_eq({name, "/stable"}, stab_err, 0);
        check_eq({name, "/sel_we"}, sel_err, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_rd = 32'h0;
        for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check_eq({name, "/cyc_stb_we"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
        check_eq({name, "/adr_dat"}, {wb_adr_o, wb_dat_o}, 0);
        check_eq({name, "/status"}, {busy, done, error, err_code, err_step, step_idx}, 0);
        check_eq({name, "/rd"}, {rd_data, rd_valid}, 0);
    endtask

    logic [7:0] radr;
    int len, k;
    bit got_stb;

    initial begin
        waits = 0; dead = 0; stray = 0; poll_switch = 0;
        poll_before = 0; poll_after = 0; cyc_no = 0;
        clear_table();
        do_reset();
        check_idle("reset");

        // Two writes then a read-back, zero-wait slave
        clear_table();
        set_step(0, 2'b01, 8'h18, 32'h7FFF, 0);
        set_step(1, 2'b01, 8'h1C, 32'h1, 0);
        set_step(2, 2'b10, 8'h18, 0, 0);
        run_script("wwr", 0, 0, 0);
        check_eq("wwr/rd_data_abs", rd_data, 32'h7FFF);
        check_eq("wwr/step_idx_abs", step_idx, 3);
        check_eq("wwr/rdv_abs", rdv_cnt, 1);
        check_eq("wwr/nstarts", starts.size(), 3);
        if (starts.size() == 3) begin
            check_eq("wwr/spacing0", starts[1] - starts[0], 2);
            check_eq("wwr/spacing1", starts[2] - starts[1], 2);
        end

        // Poll that matches on the 4th read
        clear_table();
        set_step(0, 2'b11, POLL_ADR, 32'h1, 32'h1);
        poll_switch = poll_reads + 3; poll_before = 0; poll_after = 1;
        run_script("poll_ok", 0, 0, 0);
        check_eq("poll_ok/reads", obs_q.size(), 4);
        check_eq("poll_ok/done_abs", {done, error}, 2'b10);
        for (int i = 1; i < starts.size(); i++)
            check_eq($sformatf("poll_ok/gap%0d", i), starts[i] - starts[i-1], 1 + POLL_GAP);

        // Slave never acks the third step
        clear_table();
        set_step(0, 2'b01, 8'h10, 32'h5, 0);
        set_step(1, 2'b10, 8'h10, 0, 0);
        set_step(2, 2'b01, DEAD_ADR, 32'h1, 0);
        run_script("timeout", 0, 1, 0);
        check_eq("timeout/cyc_len", last_run, ACK_TIMEOUT);
        check_eq("timeout/code_abs", err_code, 2'b01);
        check_eq("timeout/step_abs", err_step, 2);

        // Poll that never matches, then a rerun clears the error
        clear_table();
        set_step(0, 2'b01, 8'h08, 32'h3, 0);
        set_step(1, 2'b11, POLL_ADR, 32'h1, 32'h1);
        poll_switch = 32'hFFFF_FFFF; poll_before = 0;
        run_script("poll_lim", 0, 0, 0);
        check_eq("poll_lim/reads", obs_q.size(), 1 + POLL_LIMIT);
        check_eq("poll_lim/code_abs", err_code, 2'b10);
        clear_table();
        set_step(0, 2'b01, 8'h18, 32'h1234, 0);
        set_step(1, 2'b10, 8'h18, 0, 0);
        run_script("rerun", 1, 0, 1);
        check_eq("rerun/error_clear", {error, err_code}, 0);

        // Asynchronous reset during an active bus cycle
        clear_table();
        set_step(0, 2'b01, 8'h20, 32'hA5A5, 0);
        set_step(1, 2'b01, 8'h24, 32'h5A5A, 0);
        waits = 3; dead = 0; stray = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        got_stb = 0;
        for (int i = 0; i < 20 && !got_stb; i++) begin
            if (wb_stb_o && wb_we_o) got_stb = 1;
            else @(negedge clk);
        end
        check_eq("arst/stb_before", got_stb, 1);
        #2 reset_n = 1'b0;
        #1 check_eq("arst/drop", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_rd = 32'h0;
        for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
        @(negedge clk);
        check_idle("arst_after");

        // Wait states: addr/data/we held and a single transfer per step
        clear_table();
        set_step(0, 2'b01, 8'h30, 32'hDEAD_BEEF, 0);
        set_step(1, 2'b01, 8'h31, 32'h0BAD_F00D, 0);
        set_step(2, 2'b10, 8'h30, 0, 0);
        set_step(3, 2'b10, 8'h31, 0, 0);
        run_script("wait3", 3, 0, 0);
        check_eq("wait3/rd_abs", rd_data, 32'h0BAD_F00D);

        // Randomized scripts
        for (int r = 0; r < 30; r++) begin
            clear_table();
            len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) begin
                k = $urandom_range(1, 3);
                radr = 8'h10 + 8'($urandom_range(0, 7));
                if (k == 3) set_step(i, 2'b11, POLL_ADR, 32'($urandom_range(0, 3)), 32'h3);
                else        set_step(i, 2'(k), radr, $urandom, 0);
            end
            dead = ($urandom_range(0, 5) == 0);
            if (dead) begin
                k = $urandom_range(0, len - 1);
                if (t_op[k] != 2'b11) t_adr[k] = DEAD_ADR;
            end
            poll_before = 32'($urandom_range(0, 3));
            poll_after  = 32'($urandom_range(0, 3));
            poll_switch = poll_reads + 32'($urandom_range(0, 5));
            run_script($sformatf("rnd%0d", r), $urandom_range(0, 3), dead, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
